ctrl_untilsat_seq: RTL

CTRL_UNTILSAT_SEQ -- requirements
Module: ctrl_untilsat_seq

---
 rtl/ctrl_untilsat_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ctrl_untilsat_seq.sv
// Issue-until-saturated sequencer: latches an opcode's control word and re-issues it
// (ISSUE/GAP pairs) until the datapath saturates, the iteration limit is hit, or abort.
module ctrl_untilsat_seq #(
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [6:0]        op,
   input  logic [ITER_W-1:0] max_iter,
   input  logic              abort,
   output logic [6:0]        dec_op,
   input  logic [25:0]       dec_cw,
   output logic [25:0]       cw,
   output logic              cw_valid,
   input  logic              cw_ack,
   input  logic              sat,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status
);

   typedef enum logic [2:0] {IDLE, LATCH, ISSUE, GAP, DONE} state_t;

   localparam logic [1:0] ST_SAT   = 2'b00;
   localparam logic [1:0] ST_LIMIT = 2'b01;
   localparam logic [1:0] ST_ABORT = 2'b10;
   localparam logic [1:0] ST_ZERO  = 2'b11;

   state_t            state;
   logic [ITER_W-1:0] limit;
   logic [ITER_W:0]   cnt_inc;
   logic              limit_hit;

   // One extra bit so the compare never sees a wrapped count.
   assign cnt_inc   = {1'b0, iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
   assign limit_hit = (cnt_inc == {1'b0, limit});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_ready <= 1'b0;
         dec_op   <= '0;
         limit    <= '0;
         cw       <= '0;
         cw_valid <= 1'b0;
         iter_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         status   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid && op_ready) begin
                  dec_op   <= op;
                  limit    <= max_iter;
                  iter_cnt <= '0;
                  op_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= LATCH;
               end else begin
                  op_ready <= 1'b1;
               end
            end
            LATCH: begin
               cw <= dec_cw;
               if (abort) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_ABORT;
               end else if (limit == '0) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_ZERO;
               end else begin
                  state    <= ISSUE;
                  cw_valid <= 1'b1;
               end
            end
            ISSUE: begin
               // Abort wins over a same-cycle ack: the transfer is not counted.
               if (abort) begin
                  cw_valid <= 1'b0;
                  state    <= DONE;
                  done     <= 1'b1;
                  status   <= ST_ABORT;
               end else if (cw_ack) begin
                  cw_valid <= 1'b0;
                  iter_cnt <= cnt_inc[ITER_W-1:0];
                  if (sat) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     status <= ST_SAT;
                  end else if (limit_hit) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     status <= ST_LIMIT;
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (abort) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  status <= ST_ABORT;
               end else begin
                  state    <= ISSUE;
                  cw_valid <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               op_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               cw_valid <= 1'b0;
               busy     <= 1'b0;
               op_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
